axi_rd_tid_tracker: RTL and testbench

Read-transaction ID tracker between the data-cache memory read request/response port and the AXI4 master adapter. Each accepted cache read gets a free AXI ID from a pool; the cache transaction ID (tid) is stored against it and restored on every R beat, so out-of-order AXI responses return to the cache with the right tid. The AR channel is registered; the R channel is a combinational lookup.

---
 rtl/axi_rd_tid_pkg.sv | 37 +++
 rtl/rd_tid_free_list.sv | 24 ++
 rtl/axi_rd_tid_tracker.sv | 197 +++++++++++++++++++
 tb/tb_axi_rd_tid_tracker.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_tid_pkg.sv
// Shared types for the AXI read-ID tracker: per-ID table entry, registered AR
// request, default widths and the outstanding-cap legality check.
package axi_rd_tid_pkg;

  localparam int unsigned PkgAxiIdWidth  = 4;
  localparam int unsigned PkgMemTidWidth = 4;
  localparam int unsigned PkgAddrWidth   = 64;
  localparam int unsigned PkgLenWidth    = 8;

  // One entry per AXI ID: allocated flag and the cache tid it belongs to.
  typedef struct packed {
    logic                      valid;
    logic [PkgMemTidWidth-1:0] tid;
  } id_entry_t;

  // Contents of the AR output register.
  typedef struct packed {
    logic [PkgAddrWidth-1:0]  addr;
    logic [PkgAxiIdWidth-1:0] id;
    logic [PkgLenWidth-1:0]   len;
  } ar_req_t;

  // The outstanding cap must be at least one and no larger than the ID pool.
  function automatic bit max_outstanding_ok(input int unsigned id_width,
                                            input int unsigned max_out);
    return (max_out >= 1) && (max_out <= (32'd1 << id_width));
  endfunction

  // The shared struct types are sized by the package widths above.
  function automatic bit widths_match_pkg(input int unsigned id_width,
                                          input int unsigned tid_width,
                                          input int unsigned addr_width);
    return (id_width == PkgAxiIdWidth) && (tid_width == PkgMemTidWidth) &&
           (addr_width == PkgAddrWidth);
  endfunction

endpackage

// File: rtl/rd_tid_free_list.sv
// Free-ID finder: given the free vector, returns the lowest-index free ID and
// whether any ID is free. Purely combinational (trailing-zero count).
module rd_tid_free_list #(
  parameter int unsigned NumIds   = 16,
  parameter int unsigned IdxWidth = 4
) (
  input  logic [NumIds-1:0]   free_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = NumIds; i > 0; i--) begin
      if (free_i[i-1]) begin
        idx_o = IdxWidth'(i - 1);
      end
    end
  end

  assign any_o = |free_i;

endmodule

// File: rtl/axi_rd_tid_tracker.sv
// AXI read transaction-ID tracker. Allocates a free AXI ID per accepted cache
// read, remembers the cache tid against it and restores it on every R beat.
// AR channel registered; R channel is a combinational lookup.
// Optional: AXI_RD_TID_TRACKER_CHECK_EN drops R beats on unallocated IDs and
// pulses err_unexp_id_o.
module axi_rd_tid_tracker
  import axi_rd_tid_pkg::*;
#(
  parameter int unsigned AxiIdWidth     = PkgAxiIdWidth,
  parameter int unsigned MemTidWidth    = PkgMemTidWidth,
  parameter int unsigned AddrWidth      = PkgAddrWidth,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  // cache read request
  input  logic                                    req_valid_i,
  output logic                                    req_ready_o,
  input  logic [AddrWidth-1:0]                    req_addr_i,
  input  logic [MemTidWidth-1:0]                  req_tid_i,
  input  logic [7:0]                              req_len_i,
  // AXI AR
  output logic                                    ar_valid_o,
  input  logic                                    ar_ready_i,
  output logic [AddrWidth-1:0]                    ar_addr_o,
  output logic [AxiIdWidth-1:0]                   ar_id_o,
  output logic [7:0]                              ar_len_o,
  // AXI R
  input  logic                                    r_valid_i,
  output logic                                    r_ready_o,
  input  logic [AxiIdWidth-1:0]                   r_id_i,
  input  logic [DataWidth-1:0]                    r_data_i,
  input  logic [1:0]                              r_resp_i,
  input  logic                                    r_last_i,
  // cache response
  output logic                                    rsp_valid_o,
  input  logic                                    rsp_ready_i,
  output logic [MemTidWidth-1:0]                  rsp_tid_o,
  output logic [DataWidth-1:0]                    rsp_data_o,
  output logic                                    rsp_last_o,
  output logic                                    rsp_error_o,
  // status
  output logic [$clog2(MaxOutstanding+1)-1:0]     outstanding_o,
  output logic                                    busy_o,
  output logic                                    err_unexp_id_o
);

  localparam int unsigned NumIds   = 2 ** AxiIdWidth;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam bit          ParamsOk = max_outstanding_ok(AxiIdWidth, MaxOutstanding) &&
                                     widths_match_pkg(AxiIdWidth, MemTidWidth, AddrWidth);

  if (!ParamsOk) begin : g_param_check
    $error("axi_rd_tid_tracker: illegal MaxOutstanding or widths differ from axi_rd_tid_pkg");
  end

  id_entry_t             tbl_q [NumIds];
  id_entry_t             tbl_d [NumIds];
  logic [NumIds-1:0]     free_vec;
  logic [AxiIdWidth-1:0] alloc_id;
  logic                  any_free;
  logic                  below_cap;
  logic                  alloc;
  logic                  dealloc;
  logic                  entry_valid;
  logic                  hit;

  ar_req_t               ar_q, ar_d;
  logic                  ar_valid_q, ar_valid_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic                  unused_resp_lsb;
  assign unused_resp_lsb = r_resp_i[0];

  // Free vector from the pre-update table: an ID released this cycle is not
  // visible as free until the next cycle.
  always_comb begin
    free_vec = '0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      free_vec[i] = !tbl_q[i].valid;
    end
  end

  rd_tid_free_list #(
    .NumIds   (NumIds),
    .IdxWidth (AxiIdWidth)
  ) u_free_list (
    .free_i (free_vec),
    .idx_o  (alloc_id),
    .any_o  (any_free)
  );

  assign below_cap   = cnt_q < CntWidth'(MaxOutstanding);
  assign req_ready_o = (!ar_valid_q || ar_ready_i) && any_free && below_cap;
  assign alloc       = req_valid_i && req_ready_o;

  assign entry_valid = tbl_q[r_id_i].valid;

`ifdef AXI_RD_TID_TRACKER_CHECK_EN
  logic err_q;

  // Beats on unallocated IDs are swallowed: always ready, never forwarded.
  assign hit            = entry_valid;
  assign rsp_valid_o    = r_valid_i && hit;
  assign r_ready_o      = hit ? rsp_ready_i : 1'b1;
  assign err_unexp_id_o = err_q;

  // Single-cycle pulse the cycle after an unexpected-ID beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= r_valid_i && !hit;
    end
  end
`else
  assign hit            = 1'b1;
  assign rsp_valid_o    = r_valid_i;
  assign r_ready_o      = rsp_ready_i;
  assign err_unexp_id_o = 1'b0;
`endif

  assign rsp_tid_o   = tbl_q[r_id_i].tid;
  assign rsp_data_o  = r_data_i;
  assign rsp_last_o  = r_last_i;
  assign rsp_error_o = r_resp_i[1];

  // Only a last beat on an allocated entry releases it, so the counter tracks
  // allocated entries even if a stale ID is forwarded unchecked.
  assign dealloc = r_valid_i && r_ready_o && r_last_i && hit && entry_valid;

  // Table update: release first, then allocate (the two never hit one index).
  always_comb begin
    for (int unsigned i = 0; i < NumIds; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    if (dealloc) begin
      tbl_d[r_id_i].valid = 1'b0;
    end
    if (alloc) begin
      tbl_d[alloc_id].valid = 1'b1;
      tbl_d[alloc_id].tid   = req_tid_i;
    end
  end

  // AR register: load on accept, otherwise drain on ar_ready_i.
  always_comb begin
    ar_d       = ar_q;
    ar_valid_d = ar_valid_q;
    if (alloc) begin
      ar_valid_d = 1'b1;
      ar_d.addr  = req_addr_i;
      ar_d.id    = alloc_id;
      ar_d.len   = req_len_i;
    end else if (ar_ready_i) begin
      ar_valid_d = 1'b0;
    end
  end

  // Outstanding counter; allocation is gated at the cap so it cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({alloc, dealloc})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        tbl_q[i] <= '0;
      end
      ar_q       <= '0;
      ar_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      ar_q       <= ar_d;
      ar_valid_q <= ar_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ar_valid_o    = ar_valid_q;
  assign ar_addr_o     = ar_q.addr;
  assign ar_id_o       = ar_q.id;
  assign ar_len_o      = ar_q.len;
  assign outstanding_o = cnt_q;
  assign busy_o        = cnt_q != '0;

endmodule

// File: tb/tb_axi_rd_tid_tracker.sv
// Self-checking bench for axi_rd_tid_tracker: directed scenarios followed by a
// randomized phase, all checked every cycle against a table/queue model.
module tb_axi_rd_tid_tracker;

  localparam int NI = 16;
  localparam int MO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [3:0]  req_tid;
  logic [7:0]  req_len;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        rsp_last, rsp_error;
  logic [4:0]  outstanding;
  logic        busy, err_unexp;

  always #5 clk = ~clk;

  axi_rd_tid_tracker #(
    .AxiIdWidth     (4),
    .MemTidWidth    (4),
    .AddrWidth      (64),
    .DataWidth      (64),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_tid_i      (req_tid),
    .req_len_i      (req_len),
    .ar_valid_o     (ar_valid),
    .ar_ready_i     (ar_ready),
    .ar_addr_o      (ar_addr),
    .ar_id_o        (ar_id),
    .ar_len_o       (ar_len),
    .r_valid_i      (r_valid),
    .r_ready_o      (r_ready),
    .r_id_i         (r_id),
    .r_data_i       (r_data),
    .r_resp_i       (r_resp),
    .r_last_i       (r_last),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_tid_o      (rsp_tid),
    .rsp_data_o     (rsp_data),
    .rsp_last_o     (rsp_last),
    .rsp_error_o    (rsp_error),
    .outstanding_o  (outstanding),
    .busy_o         (busy),
    .err_unexp_id_o (err_unexp)
  );

  int unsigned ntests = 0;
  int unsigned nfail  = 0;

  // Reference model: which IDs are held, their tids, count, pending AR.
  bit          mv [NI];
  logic [3:0]  mt [NI];
  int          mcnt;
  bit          mar_v;
  logic [3:0]  mar_id;
  logic [63:0] mar_addr;
  logic [7:0]  mar_len;
  bit          merr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NI; i++) if (!mv[i]) return i;
    return -1;
  endfunction

  function automatic bit beat_hits(input logic [3:0] id);
`ifdef AXI_RD_TID_TRACKER_CHECK_EN
    return mv[id];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mv[i] = 1'b0;
      mt[i] = '0;
    end
    mcnt  = 0;
    mar_v = 1'b0;
    merr  = 1'b0;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = '0; req_tid = '0; req_len = '0;
    ar_ready  = 1'b1;
    r_valid   = 1'b0; r_id = '0; r_data = '0; r_resp = '0; r_last = 1'b0;
    rsp_ready = 1'b1;
  endtask

  // One clock: check combinational outputs, advance model and DUT, then check
  // the registered outputs.
  task automatic cycle();
    int          fid;
    bit          exp_rdy, hit, exp_rr, fr, al, err_n;
    logic [3:0]  c_rid, c_tid;
    logic [63:0] c_addr;
    logic [7:0]  c_len;
    #1;
    fid     = lowest_free();
    exp_rdy = (!mar_v || ar_ready) && (fid >= 0) && (mcnt < MO);
    hit     = beat_hits(r_id);
    exp_rr  = hit ? rsp_ready : 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("r_ready", r_ready, exp_rr);
    chk("rsp_valid", rsp_valid, r_valid && hit);
    if (r_valid && hit) begin
      if (mv[r_id]) chk("rsp_tid", rsp_tid, mt[r_id]);
      chk("rsp_data", rsp_data, r_data);
      chk("rsp_last", rsp_last, r_last);
      chk("rsp_error", rsp_error, r_resp[1]);
    end
    fr     = r_valid && exp_rr && r_last && mv[r_id];
    al     = req_valid && exp_rdy;
    err_n  = r_valid && !hit;
    c_rid  = r_id;
    c_tid  = req_tid;
    c_addr = req_addr;
    c_len  = req_len;
    @(posedge clk);
    #1;
    if (fr) begin
      mv[c_rid] = 1'b0;
      mcnt--;
    end
    if (al) begin
      mv[fid]  = 1'b1;
      mt[fid]  = c_tid;
      mcnt++;
      mar_v    = 1'b1;
      mar_id   = 4'(fid);
      mar_addr = c_addr;
      mar_len  = c_len;
    end else if (ar_ready) begin
      mar_v = 1'b0;
    end
    merr = err_n;
    chk("outstanding", outstanding, mcnt);
    chk("busy", busy, mcnt != 0);
    chk("ar_valid", ar_valid, mar_v);
    if (mar_v) begin
      chk("ar_id", ar_id, mar_id);
      chk("ar_addr", ar_addr, mar_addr);
      chk("ar_len", ar_len, mar_len);
    end
    chk("err_unexp", err_unexp, merr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ar_valid", ar_valid, 1'b0);
    chk("rst_err", err_unexp, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_req(input logic [63:0] a, input logic [3:0] t, input logic [7:0] l);
    req_valid = 1'b1; req_addr = a; req_tid = t; req_len = l;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic send_last(input logic [3:0] id);
    r_valid = 1'b1; r_id = id; r_last = 1'b1; r_resp = 2'b00;
    r_data  = {$urandom, $urandom};
    cycle();
    r_valid = 1'b0; r_last = 1'b0;
  endtask

  initial begin
    int ids [$];
    int beat, nbeats, nlast;
    bit tog;

    idle_inputs();
    model_reset();
    do_reset();

    // Single read
    send_req(64'h8000_0000, 4'd5, 8'd0);
    chk("single_ar_id", ar_id, 4'd0);
    chk("single_out1", outstanding, 1);
    r_valid = 1'b1; r_id = 4'd0; r_last = 1'b1; r_data = 64'hDEAD_BEEF;
    #1;
    chk("single_rsp_tid", rsp_tid, 4'd5);
    cycle();
    r_valid = 1'b0; r_last = 1'b0;
    chk("single_out0", outstanding, 0);

    // Out-of-order completion
    send_req(64'h100, 4'd1, 8'd0);
    chk("ooo_id0", ar_id, 4'd0);
    send_req(64'h200, 4'd2, 8'd0);
    chk("ooo_id1", ar_id, 4'd1);
    send_req(64'h300, 4'd3, 8'd0);
    chk("ooo_id2", ar_id, 4'd2);
    r_valid = 1'b1; r_last = 1'b1;
    r_id = 4'd2; #1; chk("ooo_tid3", rsp_tid, 4'd3); cycle();
    r_id = 4'd0; #1; chk("ooo_tid1", rsp_tid, 4'd1); cycle();
    r_id = 4'd1; #1; chk("ooo_tid2", rsp_tid, 4'd2); cycle();
    r_valid = 1'b0; r_last = 1'b0;
    chk("ooo_out0", outstanding, 0);

    // Full pool, then recycle ID 7
    for (int i = 0; i < NI; i++) send_req({$urandom, $urandom}, 4'($urandom), 8'($urandom));
    #1;
    chk("full_ready0", req_ready, 1'b0);
    chk("full_out16", outstanding, 16);
    send_last(4'd7);
    #1;
    chk("full_ready1", req_ready, 1'b1);
    send_req(64'h7000, 4'd9, 8'd0);
    chk("full_reuse7", ar_id, 4'd7);

    // Simultaneous free and allocate at 15 outstanding
    send_last(4'd3);
    chk("sim_out15", outstanding, 15);
    req_valid = 1'b1; req_addr = 64'h4000; req_tid = 4'hE; req_len = 8'd0;
    r_valid = 1'b1; r_id = 4'd4; r_last = 1'b1;
    cycle();
    req_valid = 1'b0; r_valid = 1'b0; r_last = 1'b0;
    chk("sim_out_keep", outstanding, 15);
    chk("sim_not_freed", ar_id != 4'd4, 1'b1);
    chk("sim_id3", ar_id, 4'd3);

    // Drain
    for (int i = NI - 1; i >= 0; i--) if (mv[i]) send_last(4'(i));
    chk("drain_out0", outstanding, 0);

    // Four-beat burst with response backpressure
    send_req(64'h9000, 4'hA, 8'd3);
    beat = 0; nbeats = 0; nlast = 0; tog = 1'b0;
    for (int k = 0; k < 16 && beat < 4; k++) begin
      r_valid = 1'b1; r_id = ar_id; r_data = {$urandom, $urandom};
      r_last = (beat == 3); r_resp = (beat == 1) ? 2'b10 : 2'b00;
      rsp_ready = tog;
      #1;
      if (beat == 1) chk("burst_err", rsp_error, 1'b1);
      if (beat < 3) chk("burst_held", outstanding, 1);
      if (rsp_valid && rsp_ready) begin
        nbeats++;
        if (rsp_last) nlast++;
      end
      cycle();
      if (tog) beat++;
      tog = !tog;
    end
    r_valid = 1'b0; r_last = 1'b0; rsp_ready = 1'b1;
    chk("burst_beats", nbeats, 4);
    chk("burst_lasts", nlast, 1);
    chk("burst_freed", outstanding, 0);

`ifdef AXI_RD_TID_TRACKER_CHECK_EN
    // Beat on an unallocated ID is dropped
    r_valid = 1'b1; r_id = 4'd9; r_last = 1'b1; rsp_ready = 1'b0;
    #1;
    chk("unexp_rsp_valid", rsp_valid, 1'b0);
    chk("unexp_r_ready", r_ready, 1'b1);
    cycle();
    r_valid = 1'b0; r_last = 1'b0; rsp_ready = 1'b1;
    chk("unexp_pulse", err_unexp, 1'b1);
    chk("unexp_out", outstanding, 0);
    cycle();
    chk("unexp_pulse_end", err_unexp, 1'b0);
`endif

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr  = {$urandom, $urandom};
      req_tid   = 4'($urandom);
      req_len   = 8'($urandom);
      ar_ready  = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      ids.delete();
      for (int i = 0; i < NI; i++) if (mv[i]) ids.push_back(i);
      if (ids.size() > 0 && $urandom_range(0, 1) == 1) begin
        r_valid = 1'b1;
        r_id    = 4'(ids[$urandom_range(0, ids.size() - 1)]);
      end else begin
        r_valid = 1'b0;
      end
      r_last = ($urandom_range(0, 2) == 0);
      r_resp = 2'($urandom);
      r_data = {$urandom, $urandom};
      cycle();
    end
    idle_inputs();

    // Reset in the middle of a burst
    send_req(64'hA000, 4'h6, 8'd7);
    send_req(64'hB000, 4'h2, 8'd0);
    r_valid = 1'b1; r_id = 4'd0; r_last = 1'b0;
    cycle();
    rsp_ready = 1'b0;
    do_reset();
    idle_inputs();
    chk("midrst_out0", outstanding, 0);
    chk("midrst_arv0", ar_valid, 1'b0);
    send_req(64'hC000, 4'hC, 8'd0);
    chk("post_rst_id0", ar_id, 4'd0);
    send_last(4'd0);
    chk("post_rst_out0", outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
